// File: rtl/mac_array_sequencer_pkg.sv
// mac_array_sequencer_pkg: instruction codes, operation encoding and FSM states shared by the sequencer.
package mac_array_sequencer_pkg;

    localparam logic [31:0] CODE_COMPUTE    = 32'd87;
    localparam logic [31:0] CODE_LOADIFMAPS = 32'd88;
    localparam logic [1:0]  OP_POOL         = 2'b10;
    localparam logic [4:0]  MAX_KERNEL      = 5'd5;

    typedef enum logic [2:0] {
        IDLE,
        W_READ,
        W_DRAIN,
        W_COMMIT,
        IFMAP,
        DONE
    } seq_state_t;

endpackage

// File: rtl/mac_seq_beat_counter.sv
// mac_seq_beat_counter: loadable down-counter with zero flag; decrement is ignored at zero.
module mac_seq_beat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    assign zero = count == '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (load) count <= load_value;
        else if (dec && !zero) count <= count - WIDTH'(1);

endmodule

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer: sequences weight BRAM reads and ifmap beats into the MAC array.
// Define MAC_SEQ_PERF_CNT_EN to build the ifmap stall-cycle counter.
module mac_array_sequencer
    import mac_array_sequencer_pkg::*;
#(
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int BEAT_WIDTH         = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inst_valid,
    output logic                          inst_ready,
    input  logic [31:0]                   inst_code,
    input  logic [4:0]                    kernel_size_cfg,
    input  logic [1:0]                    operation_cfg,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr,
    input  logic [BEAT_WIDTH-1:0]         beat_count,
    input  logic                          ifmaps_fifo_empty,
    output logic                          bram_en,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
    output logic                          load_weight_preload,
    output logic                          load_MAC_weight,
    output logic                          load_ifmaps,
    output logic                          pooling_compute,
    output logic [1:0]                    operation,
    output logic [4:0]                    kernel_size,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [31:0]                   stall_cycles
);

    // Counter must hold both the beat count and K*K-1 (24 at most).
    localparam int CW = BEAT_WIDTH > 5 ? BEAT_WIDTH : 5;

    seq_state_t    state;
    logic          accept, is_compute, is_ifmap, kernel_ok, cnt_load, cnt_dec, cnt_zero;
    logic [9:0]    kk_m1;
    logic [CW-1:0] cnt_load_value, cnt;

    assign inst_ready     = state == IDLE;
    assign busy           = !inst_ready;
    assign accept         = inst_valid && inst_ready;
    assign is_compute     = inst_code == CODE_COMPUTE;
    assign is_ifmap       = inst_code == CODE_LOADIFMAPS;
    assign kernel_ok      = kernel_size_cfg != 5'd0 && kernel_size_cfg <= MAX_KERNEL;
    assign kk_m1          = 10'(kernel_size_cfg) * 10'(kernel_size_cfg) - 10'd1;
    assign cnt_load       = accept && ((is_compute && kernel_ok) || is_ifmap);
    assign cnt_load_value = is_compute ? CW'(kk_m1) : CW'(beat_count);
    // The FIFO pop must see empty in the same cycle, so this strobe is decoded from state.
    assign load_ifmaps    = state == IFMAP && !ifmaps_fifo_empty && !cnt_zero;
    assign cnt_dec        = (state == W_READ) || load_ifmaps;

    mac_seq_beat_counter #(.WIDTH(CW)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .dec       (cnt_dec),
        .count     (cnt),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            bram_en             <= 1'b0;
            bram_addr           <= '0;
            load_weight_preload <= 1'b0;
            load_MAC_weight     <= 1'b0;
            pooling_compute     <= 1'b0;
            operation           <= 2'b00;
            kernel_size         <= 5'd0;
            done                <= 1'b0;
            err                 <= 1'b0;
        end else begin
            load_weight_preload <= bram_en;
            load_MAC_weight     <= 1'b0;
            pooling_compute     <= load_ifmaps && operation == OP_POOL;
            done                <= 1'b0;
            err                 <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (cnt_load) begin
                        state       <= is_compute ? W_READ : IFMAP;
                        bram_en     <= is_compute;
                        bram_addr   <= is_compute ? weight_base_addr : bram_addr;
                        operation   <= operation_cfg;
                        kernel_size <= kernel_size_cfg;
                    end else err <= 1'b1;
                end
                W_READ: if (cnt_zero) begin
                    state   <= W_DRAIN;
                    bram_en <= 1'b0;
                end else bram_addr <= bram_addr + BRAM_ADDRESS_WIDTH'(1);
                W_DRAIN: begin
                    state           <= W_COMMIT;
                    load_MAC_weight <= 1'b1;
                end
                W_COMMIT: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                IFMAP: if (cnt_zero) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAC_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stall_cycles <= '0;
        else if (accept) stall_cycles <= '0;
        else if (state == IFMAP && ifmaps_fifo_empty && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mac_array_sequencer.sv
// tb_mac_array_sequencer: directed and randomized checks of the sequencer against a cycle-level behavioural model.
module tb_mac_array_sequencer;

    localparam int AW = 12;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_code;
    logic [4:0]    kernel_size_cfg;
    logic [1:0]    operation_cfg;
    logic [AW-1:0] weight_base_addr;
    logic [BW-1:0] beat_count;
    logic          ifmaps_fifo_empty;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic          load_weight_preload, load_MAC_weight, load_ifmaps, pooling_compute;
    logic [1:0]    operation;
    logic [4:0]    kernel_size;
    logic          busy, done, err;
    logic [31:0]   stall_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_array_sequencer #(.BRAM_ADDRESS_WIDTH(AW), .BEAT_WIDTH(BW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .inst_valid         (inst_valid),
        .inst_ready         (inst_ready),
        .inst_code          (inst_code),
        .kernel_size_cfg    (kernel_size_cfg),
        .operation_cfg      (operation_cfg),
        .weight_base_addr   (weight_base_addr),
        .beat_count         (beat_count),
        .ifmaps_fifo_empty  (ifmaps_fifo_empty),
        .bram_en            (bram_en),
        .bram_addr          (bram_addr),
        .load_weight_preload(load_weight_preload),
        .load_MAC_weight    (load_MAC_weight),
        .load_ifmaps        (load_ifmaps),
        .pooling_compute    (pooling_compute),
        .operation          (operation),
        .kernel_size        (kernel_size),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .stall_cycles       (stall_cycles)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Random instruction fields while busy; never accepted because inst_ready is low.
    task automatic drive_junk();
        inst_valid       = inst_ready ? 1'b0 : 1'($urandom);
        inst_code        = $urandom_range(86, 89);
        kernel_size_cfg  = 5'($urandom);
        operation_cfg    = 2'($urandom);
        weight_base_addr = AW'($urandom);
        beat_count       = BW'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".strobes"}, {bram_en, load_weight_preload, load_MAC_weight, load_ifmaps, pooling_compute}, 0);
        check({tag, ".bram_addr"}, bram_addr, 0);
        check({tag, ".busy_done_err"}, {busy, done, err}, 0);
        check({tag, ".operation"}, operation, 0);
        check({tag, ".kernel_size"}, kernel_size, 0);
        check({tag, ".stall_cycles"}, stall_cycles, 0);
    endtask

    task automatic idle_tail(input string tag);
        @(negedge clk);
        check({tag, ".idle_ready"}, {inst_ready, busy, done}, 3'b100);
    endtask

    // Called just after a negedge in IDLE; the next posedge accepts the instruction.
    task automatic run_compute(input string tag, input int k, input logic [AW-1:0] base);
        int kk = k * k;
        int n_en = 0, n_pre = 0, n_mac = 0, n_done = 0;
        int bad_addr = 0, bad_lag = 0, bad_cont = 0, bad_rdy = 0, bad_other = 0;
        int last_en = -1, last_pre = -1, mac_c = -1, done_c = -1;
        logic prev_en = 1'b0;
        logic [1:0] op = 2'($urandom);
        inst_valid = 1'b1; inst_code = 32'd87; kernel_size_cfg = 5'(k);
        operation_cfg = op; weight_base_addr = base; beat_count = BW'($urandom);
        for (int c = 1; c <= 80 && done_c < 0; c++) begin
            @(negedge clk);
            if (load_weight_preload !== prev_en) bad_lag++;
            prev_en = bram_en;
            if (bram_en) begin
                if (last_en >= 0 && last_en != c - 1) bad_cont++;
                if (bram_addr !== AW'(int'(base) + n_en)) bad_addr++;
                n_en++;
                last_en = c;
            end
            if (load_weight_preload) begin n_pre++; last_pre = c; end
            if (load_MAC_weight) begin n_mac++; mac_c = c; end
            if (done) begin n_done++; done_c = c; end
            if (inst_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
            if (load_ifmaps || pooling_compute || err) bad_other++;
            drive_junk();
        end
        inst_valid = 1'b0;
        check({tag, ".n_bram_en"}, n_en, kk);
        check({tag, ".bram_addr_seq_errs"}, bad_addr, 0);
        check({tag, ".bram_en_gaps"}, bad_cont, 0);
        check({tag, ".n_preload"}, n_pre, kk);
        check({tag, ".preload_lag_errs"}, bad_lag, 0);
        check({tag, ".n_mac_weight"}, n_mac, 1);
        check({tag, ".mac_after_last_preload"}, mac_c, last_pre + 1);
        check({tag, ".done_after_mac"}, done_c, mac_c + 1);
        check({tag, ".n_done"}, n_done, 1);
        check({tag, ".ready_busy_errs"}, bad_rdy, 0);
        check({tag, ".stray_strobes"}, bad_other, 0);
        check({tag, ".kernel_size_held"}, kernel_size, k);
        check({tag, ".operation_held"}, operation, op);
        idle_tail(tag);
    endtask

    // s0 < 0: random FIFO-empty pattern; otherwise empty for cycles s0..s0+sl-1 while beats remain.
    task automatic run_ifmap(input string tag, input int n, input logic [1:0] op, input int s0, input int sl);
        int taken = 0, stall = 0, nload = 0, npool = 0, ndone = 0, done_c = -1;
        int bad_load = 0, bad_pool = 0, bad_rdy = 0, bad_other = 0;
        logic exp_pool = 1'b0, exp_load, empty;
        logic [4:0] ks = 5'($urandom);
        inst_valid = 1'b1; inst_code = 32'd88; kernel_size_cfg = ks;
        operation_cfg = op; beat_count = BW'(n); ifmaps_fifo_empty = 1'($urandom);
        for (int c = 1; c <= 300 && done_c < 0; c++) begin
            @(negedge clk);
            if (pooling_compute !== exp_pool) bad_pool++;
            if (pooling_compute) npool++;
            if (done) begin ndone++; done_c = c; end
            if (inst_ready !== 1'b0 || busy !== 1'b1) bad_rdy++;
            if (bram_en || load_weight_preload || load_MAC_weight || err) bad_other++;
            empty = (taken < n) && (s0 < 0 ? 1'($urandom) : (c >= s0 && c < s0 + sl));
            ifmaps_fifo_empty = empty;
            if (empty) stall++;
            exp_load = !empty && taken < n;
            drive_junk();
            #1;
            if (load_ifmaps !== exp_load) bad_load++;
            if (load_ifmaps) nload++;
            if (exp_load) taken++;
            exp_pool = exp_load && op == 2'b10;
        end
        inst_valid = 1'b0;
        ifmaps_fifo_empty = 1'b0;
        check({tag, ".n_load_ifmaps"}, nload, n);
        check({tag, ".load_ifmaps_errs"}, bad_load, 0);
        check({tag, ".n_pooling"}, npool, op == 2'b10 ? n : 0);
        check({tag, ".pooling_errs"}, bad_pool, 0);
        check({tag, ".n_done"}, ndone, 1);
        check({tag, ".ready_busy_errs"}, bad_rdy, 0);
        check({tag, ".stray_strobes"}, bad_other, 0);
`ifdef MAC_SEQ_PERF_CNT_EN
        check({tag, ".stall_cycles"}, stall_cycles, stall);
`else
        check({tag, ".stall_cycles"}, stall_cycles, 0);
`endif
        check({tag, ".operation_held"}, operation, op);
        check({tag, ".kernel_size_held"}, kernel_size, ks);
        if (n == 0) check({tag, ".done_cycle"}, done_c, 2);
        idle_tail(tag);
    endtask

    task automatic run_reject(input string tag, input logic [31:0] code, input int k);
        int bad = 0;
        inst_valid = 1'b1; inst_code = code; kernel_size_cfg = 5'(k);
        operation_cfg = 2'($urandom); weight_base_addr = AW'($urandom); beat_count = BW'($urandom_range(1, 8));
        @(negedge clk);
        inst_valid = 1'b0;
        check({tag, ".err_pulse"}, err, 1);
        check({tag, ".ready_busy"}, {inst_ready, busy}, 2'b10);
        for (int c = 0; c < 3; c++) begin
            if (bram_en || load_weight_preload || load_MAC_weight || load_ifmaps || pooling_compute || done || !inst_ready) bad++;
            @(negedge clk);
        end
        check({tag, ".err_single"}, err, 0);
        check({tag, ".no_activity"}, bad, 0);
    endtask

    initial begin
        int cnt_en;
        rst_n = 1'b0; inst_valid = 1'b0; inst_code = '0; kernel_size_cfg = '0; operation_cfg = '0;
        weight_base_addr = '0; beat_count = '0; ifmaps_fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.ready", {inst_ready, busy}, 2'b10);

        run_compute("k3_base010", 3, 12'h010);
        run_compute("k2_wrap", 2, 12'hFFE);
        for (int i = 0; i < 4; i++) run_compute("k_rand", $urandom_range(1, 5), AW'($urandom));

        run_ifmap("pool4_stall3", 4, 2'b10, 3, 3);
        run_ifmap("beats0", 0, 2'($urandom), -1, 0);
        for (int i = 0; i < 4; i++)
            run_ifmap("ifmap_rand", $urandom_range(1, 12), (i % 2 == 0) ? 2'b10 : 2'($urandom), -1, 0);

        run_reject("rej_k0", 32'd87, 0);
        run_reject("rej_k6", 32'd87, 6);
        run_reject("rej_code99", 32'd99, 3);
        run_reject("rej_k31", 32'd87, 31);

        // Reset in the 5th bram_en cycle of a K=5 load.
        inst_valid = 1'b1; inst_code = 32'd87; kernel_size_cfg = 5'd5;
        operation_cfg = 2'b11; weight_base_addr = 12'h123; beat_count = '0;
        cnt_en = 0;
        for (int c = 1; c <= 20 && cnt_en < 5; c++) begin
            @(negedge clk);
            inst_valid = 1'b0;
            if (bram_en) cnt_en++;
        end
        check("midreset.reached_5th_read", cnt_en, 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset.ready_after", {inst_ready, busy}, 2'b10);
        run_compute("k5_after_reset", 5, 12'hFF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
